// File: rtl/pipelined_memory.sv
// rtl/pipelined_memory.sv - dual-array (GM/LDS) byte-addressed memory with fixed-latency tagged ack pipeline
module pipelined_memory #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int GM_BYTES  = 65536,
    parameter int LDS_BYTES = 65536,
    parameter int TAG_W     = 7,
    parameter int LATENCY   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gm_or_lds,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   addresses,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_mask,
    input  logic [TAG_W-1:0]    input_tag,
    output logic [DATA_W-1:0]   rd_data,
    output logic [TAG_W-1:0]    output_tag,
    output logic                ack,
    output logic                err
);
    localparam int NB     = DATA_W / 8;
    localparam int GM_AW  = $clog2(GM_BYTES);
    localparam int LDS_AW = $clog2(LDS_BYTES);

    logic [7:0] gm_mem  [GM_BYTES];
    logic [7:0] lds_mem [LDS_BYTES];

    logic              req;
    logic              oob;
    logic              both;
    logic [ADDR_W:0]   last_byte;
    logic [GM_AW-1:0]  gm_idx  [NB];
    logic [LDS_AW-1:0] lds_idx [NB];
    logic [DATA_W-1:0] rd_word;

    assign req  = (rd_en | wr_en) & ~rst;
    assign both = rd_en & wr_en;

    // One extra bit so an access running past the top of the address space is flagged, not wrapped
    assign last_byte = {1'b0, addresses} + (ADDR_W+1)'(NB - 1);
    assign oob = gm_or_lds ? (last_byte > (ADDR_W+1)'(LDS_BYTES - 1))
                           : (last_byte > (ADDR_W+1)'(GM_BYTES - 1));

    always_comb begin
        for (int k = 0; k < NB; k++) begin
            gm_idx[k]  = addresses[GM_AW-1:0] + GM_AW'(k);
            lds_idx[k] = addresses[LDS_AW-1:0] + LDS_AW'(k);
        end
    end

    // Combinational read happens before the same-edge write lands, so reads see old contents
    always_comb begin
        rd_word = '0;
        if (rd_en && !wr_en && !oob) begin
            for (int k = 0; k < NB; k++) begin
                rd_word[8*k +: 8] = gm_or_lds ? lds_mem[lds_idx[k]] : gm_mem[gm_idx[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en && !oob && !gm_or_lds) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_mask[k]) gm_mem[gm_idx[k]] <= wr_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en && !oob && gm_or_lds) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_mask[k]) lds_mem[lds_idx[k]] <= wr_data[8*k +: 8];
            end
        end
    end

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] err_q;
    logic [TAG_W-1:0]   tag_q  [LATENCY];
    logic [DATA_W-1:0]  data_q [LATENCY];

    // Idle slots carry zeros so the output stage needs no gating
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                vld_q[s]  <= 1'b0;
                err_q[s]  <= 1'b0;
                tag_q[s]  <= '0;
                data_q[s] <= '0;
            end
        end else begin
            vld_q[0]  <= req;
            err_q[0]  <= req & (oob | both);
            tag_q[0]  <= req ? input_tag : '0;
            data_q[0] <= req ? rd_word : '0;
            for (int s = 1; s < LATENCY; s++) begin
                vld_q[s]  <= vld_q[s-1];
                err_q[s]  <= err_q[s-1];
                tag_q[s]  <= tag_q[s-1];
                data_q[s] <= data_q[s-1];
            end
        end
    end

    assign ack        = vld_q[LATENCY-1];
    assign err        = err_q[LATENCY-1];
    assign output_tag = tag_q[LATENCY-1];
    assign rd_data    = data_q[LATENCY-1];
endmodule

// File: tb/tb_pipelined_memory.sv
// tb/tb_pipelined_memory.sv - directed scoreboard bench for pipelined_memory
module tb_pipelined_memory;
    localparam int LATENCY   = 2;
    localparam int LDS_BYTES = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gm_or_lds = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addresses = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_mask = '0;
    logic [6:0]  input_tag = '0;
    logic [31:0] rd_data;
    logic [6:0]  output_tag;
    logic        ack;
    logic        err;

    pipelined_memory #(
        .DATA_W(32), .ADDR_W(32), .GM_BYTES(65536), .LDS_BYTES(LDS_BYTES),
        .TAG_W(7), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .rst(rst), .gm_or_lds(gm_or_lds), .rd_en(rd_en), .wr_en(wr_en),
        .addresses(addresses), .wr_data(wr_data), .wr_mask(wr_mask), .input_tag(input_tag),
        .rd_data(rd_data), .output_tag(output_tag), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [6:0]  tag;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    int   edges = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic check_outputs();
        exp_t e;
        logic ea;
        ea = 1'b0;
        e.tag = '0; e.data = '0; e.err = 1'b0; e.due = 0;
        if (q.size() != 0 && q[0].due == edges) begin
            ea = 1'b1;
            e = q.pop_front();
        end
        checks++;
        assert (ack === ea) else begin
            failures++; $error("FAIL ack edge=%0d got=%0b exp=%0b", edges, ack, ea);
        end
        checks++;
        assert (output_tag === e.tag) else begin
            failures++; $error("FAIL tag edge=%0d got=%0d exp=%0d", edges, output_tag, e.tag);
        end
        checks++;
        assert (rd_data === e.data) else begin
            failures++; $error("FAIL rd_data edge=%0d got=%h exp=%h", edges, rd_data, e.data);
        end
        checks++;
        assert (err === e.err) else begin
            failures++; $error("FAIL err edge=%0d got=%0b exp=%0b", edges, err, e.err);
        end
    endtask

    task automatic tick();
        bit req_now;
        req_now = (rd_en | wr_en) && !rst;
        @(posedge clk);
        edges++;
        if (rst) q.delete();
        else if (req_now) begin
            pend.due = edges + LATENCY - 1;
            q.push_back(pend);
        end
        #1;
        check_outputs();
    endtask

    task automatic req(input bit lds, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic [6:0] t,
                       input logic [31:0] exp_data, input bit exp_err);
        gm_or_lds = lds; rd_en = r; wr_en = w; addresses = a;
        wr_data = d; wr_mask = m; input_tag = t;
        pend.tag = t; pend.data = exp_data; pend.err = exp_err;
        tick();
        gm_or_lds = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addresses = '0;
        wr_data = '0; wr_mask = '0; input_tag = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // full-word GM write then read back
        req(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 7'd5, 32'h0, 0);
        req(0, 1, 0, 32'h10, 32'h0, 4'h0, 7'd6, 32'hDEADBEEF, 0);
        idle(2);

        // partial byte-mask merge
        req(0, 0, 1, 32'h20, 32'hAAAAAAAA, 4'hF, 7'd7, 32'h0, 0);
        req(0, 0, 1, 32'h20, 32'h11223344, 4'b0101, 7'd8, 32'h0, 0);
        req(0, 1, 0, 32'h20, 32'h0, 4'h0, 7'd9, 32'hAA22AA44, 0);
        idle(2);

        // unaligned LDS write leaves GM untouched
        req(0, 0, 1, 32'h0, 32'h0, 4'hF, 7'd10, 32'h0, 0);
        req(0, 0, 1, 32'h4, 32'h0, 4'hF, 7'd11, 32'h0, 0);
        req(1, 0, 1, 32'h3, 32'h12345678, 4'hF, 7'd12, 32'h0, 0);
        req(0, 1, 0, 32'h3, 32'h0, 4'h0, 7'd13, 32'h0, 0);
        req(1, 1, 0, 32'h3, 32'h0, 4'h0, 7'd14, 32'h12345678, 0);
        idle(2);

        // out-of-range accesses near top of LDS and at address-space wrap
        req(1, 0, 1, LDS_BYTES - 4, 32'h0, 4'hF, 7'd15, 32'h0, 0);
        req(1, 1, 0, LDS_BYTES - 2, 32'h0, 4'h0, 7'd16, 32'h0, 1);
        req(1, 0, 1, LDS_BYTES - 2, 32'hFFFFFFFF, 4'hF, 7'd17, 32'h0, 1);
        req(1, 1, 0, LDS_BYTES - 4, 32'h0, 4'h0, 7'd18, 32'h0, 0);
        req(0, 1, 0, 32'hFFFFFFFE, 32'h0, 4'h0, 7'd19, 32'h0, 1);
        idle(2);

        // simultaneous read and write: write happens, err set, data zero
        req(0, 1, 1, 32'h40, 32'hCAFEF00D, 4'hF, 7'd20, 32'h0, 1);
        req(0, 1, 0, 32'h40, 32'h0, 4'h0, 7'd21, 32'hCAFEF00D, 0);
        idle(2);

        // back-to-back reads complete back-to-back in order
        req(0, 1, 0, 32'h10, 32'h0, 4'h0, 7'd1, 32'hDEADBEEF, 0);
        req(0, 1, 0, 32'h20, 32'h0, 4'h0, 7'd2, 32'hAA22AA44, 0);
        req(0, 1, 0, 32'h40, 32'h0, 4'h0, 7'd3, 32'hCAFEF00D, 0);
        req(1, 1, 0, 32'h3, 32'h0, 4'h0, 7'd4, 32'h12345678, 0);
        idle(3);

        // reset one cycle after a request drops it; requests during reset ignored
        req(0, 1, 0, 32'h10, 32'h0, 4'h0, 7'd22, 32'hDEADBEEF, 0);
        rst = 1'b1;
        rd_en = 1'b1; wr_en = 1'b1; addresses = 32'h10; wr_data = 32'h0; wr_mask = 4'hF;
        input_tag = 7'd23;
        tick();
        rd_en = 1'b0; wr_en = 1'b0; addresses = '0; wr_mask = '0; input_tag = '0;
        rst = 1'b0;
        idle(3);
        req(0, 1, 0, 32'h10, 32'h0, 4'h0, 7'd24, 32'hDEADBEEF, 0);
        req(1, 1, 0, 32'h3, 32'h0, 4'h0, 7'd25, 32'h12345678, 0);
        idle(3);

        checks++;
        assert (q.size() == 0) else begin
            failures++; $error("FAIL drain pending=%0d exp=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipelined_memory.md
PIPELINED_MEMORY -- requirements
Module: pipelined_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning access width in bits (multiple of 8, 8..128).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have parameter GM_BYTES, default 65536, meaning global-memory array size in bytes.
REQ-004 SHALL have parameter LDS_BYTES, default 65536, meaning LDS array size in bytes.
REQ-005 SHALL have parameter TAG_W, default 7, meaning request tag width.
REQ-006 SHALL have parameter LATENCY, default 2, meaning cycles from request to ack (>=1).
REQ-007 SHALL have a single clock and a synchronous, active-high reset.
REQ-008 SHALL have port clk, input, 1, the clock.
REQ-009 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-010 SHALL have port gm_or_lds, input, 1, target select (1 = LDS, 0 = global memory).
REQ-011 SHALL have port rd_en, input, 1, read request.
REQ-012 SHALL have port wr_en, input, 1, write request.
REQ-013 SHALL have port addresses, input, ADDR_W, byte start address.
REQ-014 SHALL have port wr_data, input, DATA_W, write data (little-endian).
REQ-015 SHALL have port wr_mask, input, DATA_W/8, per-byte write enable (bit i = byte i).
REQ-016 SHALL have port input_tag, input, TAG_W, request tag.
REQ-017 SHALL have port rd_data, output, DATA_W, read data, valid with ack.
REQ-018 SHALL have port output_tag, output, TAG_W, tag returned with ack.
REQ-019 SHALL have port ack, output, 1, one-cycle completion pulse.
REQ-020 SHALL have port err, output, 1, error flag, valid with ack.

Function
REQ-021 SHALL accept one request per cycle with no backpressure; a request is any cycle with rd_en | wr_en high.
REQ-022 SHALL store two independent byte arrays, GM (GM_BYTES) and LDS (LDS_BYTES), selected by gm_or_lds at request time.
REQ-023 SHALL treat byte k of an access (k = 0..DATA_W/8-1) as addresses+k; any alignment is allowed; bits [8k+7:8k] map to byte k.
REQ-024 SHALL commit a write at the request clock edge, writing only bytes whose wr_mask bit is 1.
REQ-025 SHALL sample read data from the array at the request cycle; bytes written on that same edge return old contents.
REQ-026 SHALL pulse ack exactly LATENCY cycles after the request edge; output_tag, rd_data and err SHALL hold the request's values for that cycle.
REQ-027 SHALL keep ack = 0, output_tag = 0, rd_data = 0 and err = 0 in every cycle without a completing request.
REQ-028 SHALL implement the LATENCY stages as a shift pipeline of {valid, tag, data, err}; back-to-back requests SHALL complete back-to-back, in order.
REQ-029 SHALL, when rd_en and wr_en are both 1, perform the write, return rd_data = 0, and set err = 1.
REQ-030 SHALL, when addresses + DATA_W/8 - 1 exceeds the selected array's last byte (no wrap), write nothing, return rd_data = 0, and set err = 1.
REQ-031 SHALL return rd_data = 0 with err = 0 for a legal write.
REQ-032 SHALL compute the range check at ADDR_W+1 bits so that address overflow is flagged, not wrapped.

Reset
REQ-033 SHALL, on a clock edge with rst = 1, clear all pipeline valid bits and drive ack, err, output_tag and rd_data to 0 on the next cycle.
REQ-034 SHALL drop requests in flight at reset; they SHALL never be acked.
REQ-035 SHALL ignore rd_en and wr_en while rst = 1 (no write, no ack).
REQ-036 SHALL NOT clear array contents on reset.

Verification
REQ-037 Bench SHALL check: GM write 0xDEADBEEF, mask 0xF, addr 0x10, tag 5 -> ack at +2 with tag 5, err 0; read addr 0x10 -> rd_data 0xDEADBEEF.
REQ-038 Bench SHALL check: write 0x11223344, mask 0b0101, addr 0x20, over 0xAAAAAAAA -> read returns 0xAA22AA44.
REQ-039 Bench SHALL check: LDS write 0x12345678 at addr 0x3, then GM read at 0x3 -> GM unchanged; LDS read returns 0x12345678 (unaligned).
REQ-040 Bench SHALL check: read at addr LDS_BYTES-2, gm_or_lds = 1 -> ack, err 1, rd_data 0, no write; rd_en and wr_en both high -> err 1.
REQ-041 Bench SHALL check: 4 back-to-back reads with tags 1..4 -> 4 consecutive acks, tags 1..4 in order.
REQ-042 Bench SHALL check: rst asserted 1 cycle after a request (LATENCY = 2) -> no ack for that request; all outputs 0; prior array data still readable.
